// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and exception codes for pipe_stage.
// Used by both the default and PIPE_STAGE_SKID_EN builds.
package pipe_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CODE_W-1:0] EXC_INT  = CODE_W'(0);
    localparam logic [CODE_W-1:0] EXC_ADEL = CODE_W'(4);
    localparam logic [CODE_W-1:0] EXC_ADES = CODE_W'(5);
    localparam logic [CODE_W-1:0] EXC_OV   = CODE_W'(12);

endpackage

// File: rtl/pipe_exc_merge.sv
// pipe_exc_merge: picks the exception an entry carries when captured.
// Upstream exceptions win over ones raised here; otherwise badv is the PC.
module pipe_exc_merge #(
    parameter int CODE_W = pipe_pkg::CODE_W
) (
    input  logic              in_exc,
    input  logic [CODE_W-1:0] in_code,
    input  logic [31:0]       in_badv,
    input  logic              loc_exc,
    input  logic [CODE_W-1:0] loc_code,
    input  logic [31:0]       loc_badv,
    input  logic [31:0]       pc,
    output logic              exc,
    output logic [CODE_W-1:0] code,
    output logic [31:0]       badv
);

    always_comb begin
        exc  = 1'b0;
        code = '0;
        badv = pc;
        if (in_exc) begin
            exc  = 1'b1;
            code = in_code;
            badv = in_badv;
        end else if (loc_exc) begin
            exc  = 1'b1;
            code = loc_code;
            badv = loc_badv;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: pipeline register with valid/ready handshake and exception merge.
// Define PIPE_STAGE_SKID_EN for a two-slot skid buffer with registered in_ready.
module pipe_stage #(
    parameter int DW     = 64,
    parameter int CODE_W = pipe_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_data,
    input  logic [31:0]       in_pc,
    input  logic              in_exc,
    input  logic [CODE_W-1:0] in_code,
    input  logic [31:0]       in_badv,
    input  logic              loc_exc,
    input  logic [CODE_W-1:0] loc_code,
    input  logic [31:0]       loc_badv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic [31:0]       out_pc,
    output logic              out_exc,
    output logic [CODE_W-1:0] out_code,
    output logic [31:0]       out_badv
);

    import pipe_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_EN = 1'b1;
`else
    localparam bit SKID_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [31:0]       pc;
        logic              exc;
        logic [CODE_W-1:0] code;
        logic [31:0]       badv;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, cap;

    logic              m_exc;
    logic [CODE_W-1:0] m_code;
    logic [31:0]       m_badv;
    logic              accept, retire;
    logic              load_main, load_skid, shift;

    pipe_exc_merge #(.CODE_W(CODE_W)) u_merge (
        .in_exc   (in_exc),
        .in_code  (in_code),
        .in_badv  (in_badv),
        .loc_exc  (loc_exc),
        .loc_code (loc_code),
        .loc_badv (loc_badv),
        .pc       (in_pc),
        .exc      (m_exc),
        .code     (m_code),
        .badv     (m_badv)
    );

    assign cap = '{data: in_data, pc: in_pc, exc: m_exc,
                   code: m_code, badv: m_badv};

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
                ONE: if (accept && retire) begin
                    load_main = 1'b1;
                end else if (accept && SKID_EN) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (retire) begin
                    state_d   = EMPTY;
                end
                TWO: if (retire) begin
                    state_d = ONE;
                    shift   = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main)  main_q <= cap;
            else if (shift) main_q <= skid_q;
            if (load_skid)  skid_q <= cap;
        end
    end

    // in_ready stays low in reset and for the first edge after release
`ifdef PIPE_STAGE_SKID_EN
    logic rdy_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= (state_d != TWO);
    end
    assign in_ready = rdy_q;
`else
    logic live_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) live_q <= 1'b0;
        else      live_q <= 1'b1;
    end
    assign in_ready = live_q && (out_ready || !out_valid);
`endif

    assign out_data = main_q.data;
    assign out_pc   = main_q.pc;
    assign out_exc  = main_q.exc;
    assign out_code = main_q.code;
    assign out_badv = main_q.badv;

endmodule
